// File: rtl/unidade_controle_jogo_if.sv
// Handshake bundle between the game control unit and its datapath.
// slave  : the control unit (consumes requests/status, drives controls)
// master : the datapath / environment side
interface unidade_controle_jogo_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, jogada, igual, fimC,
    output zeraC, contaC, zeraR, registraR,
    output acertou, errou, pronto, db_timeout, db_estado
  );

  modport master (
    output iniciar, jogada, igual, fimC,
    input  zeraC, contaC, zeraR, registraR,
    input  acertou, errou, pronto, db_timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Game control unit: Moore FSM sequencing 16 plays against memory, with a
// per-play timeout while waiting for the player.
module unidade_controle_jogo #(
  parameter int TIMEOUT = 5000
) (
  input  logic                    clk,
  input  logic                    rst,
  unidade_controle_jogo_if.slave  bus
);

  localparam int             CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h4,
    COMPARACAO    = 4'h5,
    PROXIMO       = 4'h6,
    FIM_ACERTO    = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERRO      = 4'hE
  } estado_t;

  estado_t       state_q, state_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          timeout;

  // Timeout fires on the TIMEOUT-th consecutive cycle spent waiting
  assign timeout = (state_q == ESPERA_JOGADA) && (tmr_q == TMAX);

  // State and timeout counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INICIAL;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Counter runs only while waiting; it stops at TMAX because the state
  // always leaves espera_jogada on that edge, so it never wraps
  always_comb begin
    tmr_d = '0;
    if (state_q == ESPERA_JOGADA && !timeout)
      tmr_d = tmr_q + 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:       if (bus.iniciar) state_d = PREPARACAO;
      PREPARACAO:    state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // a play arriving on the last allowed cycle still counts
        if (bus.jogada)    state_d = REGISTRA;
        else if (timeout)  state_d = FIM_TIMEOUT;
      end
      REGISTRA:      state_d = COMPARACAO;
      COMPARACAO: begin
        if (!bus.igual)    state_d = FIM_ERRO;
        else if (bus.fimC) state_d = FIM_ACERTO;
        else               state_d = PROXIMO;
      end
      PROXIMO:       state_d = ESPERA_JOGADA;
      FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO:
                     if (bus.iniciar) state_d = PREPARACAO;
      default:       state_d = INICIAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    bus.zeraC      = 1'b0;
    bus.contaC     = 1'b0;
    bus.zeraR      = 1'b0;
    bus.registraR  = 1'b0;
    bus.acertou    = 1'b0;
    bus.errou      = 1'b0;
    bus.pronto     = 1'b0;
    bus.db_timeout = 1'b0;
    bus.db_estado  = state_q;
    case (state_q)
      PREPARACAO: begin
        bus.zeraC = 1'b1;
        bus.zeraR = 1'b1;
      end
      REGISTRA:   bus.registraR = 1'b1;
      PROXIMO:    bus.contaC    = 1'b1;
      FIM_ACERTO: begin
        bus.pronto  = 1'b1;
        bus.acertou = 1'b1;
      end
      FIM_ERRO: begin
        bus.pronto = 1'b1;
        bus.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        bus.pronto     = 1'b1;
        bus.errou      = 1'b1;
        bus.db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Randomized bench for the game control unit. A play-level model decides
// how each round must end (all correct, wrong play, timeout or aborted by
// reset) and which state/outputs must be visible at each step.
module tb_unidade_controle_jogo;

  localparam int T = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  unidade_controle_jogo_if bus ();

  unidade_controle_jogo #(.TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int conta_seen = 0;

  // count advance pulses seen by the datapath
  always @(negedge clk) if (!rst && bus.contaC === 1'b1) conta_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // observed outputs packed {zeraC,contaC,zeraR,registraR,acertou,errou,pronto,db_timeout,db_estado}
  function automatic logic [11:0] obs();
    return {bus.zeraC, bus.contaC, bus.zeraR, bus.registraR, bus.acertou,
            bus.errou, bus.pronto, bus.db_timeout, bus.db_estado};
  endfunction

  // output table of the game: what every named state must show
  function automatic logic [11:0] expect_for(input logic [3:0] code);
    logic zc, cc, zr, rr, ac, er, pr, dt;
    {zc, cc, zr, rr, ac, er, pr, dt} = 8'h00;
    case (code)
      4'h1: begin zc = 1'b1; zr = 1'b1; end
      4'h4: rr = 1'b1;
      4'h6: cc = 1'b1;
      4'hA: begin pr = 1'b1; ac = 1'b1; end
      4'hE: begin pr = 1'b1; er = 1'b1; end
      4'hD: begin pr = 1'b1; er = 1'b1; dt = 1'b1; end
      default: ;
    endcase
    return {zc, cc, zr, rr, ac, er, pr, dt, code};
  endfunction

  task automatic check_state(input string tag, input logic [3:0] code);
    check(tag, 32'(obs()), 32'(expect_for(code)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 all correct, 1 wrong play at k, 2 timeout at play k, 3 reset during wait of play k
  task automatic run_round(input int r, input int mode, input int k);
    int d;
    bit g;
    int advanced;
    logic [3:0] final_code;
    final_code = 4'hA;
    advanced   = 0;

    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    conta_seen = 0;
    check_state("prep", 4'h1);
    step();
    check_state("espera_entry", 4'h2);

    for (int i = 0; i < 16; i++) begin
      if (mode == 2 && i == k)      d = T;
      else if ($urandom_range(0, 3) == 0) d = T - 1;
      else                          d = $urandom_range(0, 3);
      if (mode == 3 && i == k && d >= T - 1) d = T - 2;
      g = !(mode == 1 && i == k);

      // idle cycles: iniciar/igual/fimC are noise the FSM must ignore here
      for (int c = 0; c < d; c++) begin
        bus.iniciar = 1'($urandom_range(0, 1));
        bus.igual   = 1'($urandom_range(0, 1));
        bus.fimC    = 1'($urandom_range(0, 1));
        step();
      end
      bus.iniciar = 1'b0;

      if (mode == 3 && i == k) begin
        check_state("wait_before_rst", 4'h2);
        #2 rst = 1'b1;
        #1 check_state("rst_async", 4'h0);
        check("conta_before_rst", 32'(conta_seen), 32'(advanced));
        step();
        step();
        rst = 1'b0;
        step();
        check_state("after_rst_idle", 4'h0);
        $display("round %0d mode=%0d k=%0d aborted by reset after %0d plays", r, mode, k, advanced);
        return;
      end

      if (d >= T) begin
        final_code = 4'hD;
        check_state("timeout", 4'hD);
        break;
      end

      check_state("wait", 4'h2);
      bus.jogada = 1'b1;
      bus.igual  = 1'($urandom_range(0, 1));
      step();
      bus.jogada = 1'b0;
      check_state("registra", 4'h4);
      bus.igual = g;
      bus.fimC  = (i == 15);
      step();
      check_state("comparacao", 4'h5);
      step();
      if (!g) begin
        final_code = 4'hE;
        check_state("erro", 4'hE);
        break;
      end
      if (i == 15) begin
        check_state("acerto", 4'hA);
        break;
      end
      advanced++;
      check_state("proximo", 4'h6);
      step();
      check_state("espera_next", 4'h2);
    end

    // end state must hold while iniciar stays low
    for (int h = 0; h < int'($urandom_range(1, 4)); h++) begin
      bus.jogada = 1'($urandom_range(0, 1));
      step();
    end
    bus.jogada = 1'b0;
    check_state("fim_hold", final_code);
    check("conta_total", 32'(conta_seen), 32'(advanced));
    $display("round %0d mode=%0d k=%0d end=%0h advances=%0d", r, mode, k, final_code, advanced);
  endtask

  initial begin
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    bus.igual   = 1'b0;
    bus.fimC    = 1'b0;

    #1 rst = 1'b1;
    #1 check_state("reset", 4'h0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 15; c++) step();
    check_state("idle_15", 4'h0);
    $display("reset and idle checked");

    run_round(0, 0, 0);  // 16 correct plays
    run_round(1, 1, 3);  // wrong fourth play
    run_round(2, 2, 1);  // timeout after first correct play
    run_round(3, 3, 2);  // reset while waiting
    for (int r = 4; r < 40; r++)
      run_round(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 Parameter TIMEOUT, default 5000, number of clock cycles allowed in espera_jogada before timeout (5 s at 1 kHz); legal range 2..65535.
REQ-002 clock  input  1  system clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 iniciar  input  1  starts or restarts a round; level-sampled.
REQ-005 jogada  input  1  single-cycle pulse from the datapath edge detector: a play was made.
REQ-006 igual  input  1  datapath comparator: registered play equals memory word.
REQ-007 fimC  input  1  address counter at its last address (15).
REQ-008 zeraC  output  1  clear datapath address counter.
REQ-009 contaC  output  1  increment datapath address counter.
REQ-010 zeraR  output  1  clear datapath play register.
REQ-011 registraR  output  1  load datapath play register.
REQ-012 acertou  output  1  round ended with all 16 plays correct.
REQ-013 errou  output  1  round ended on a wrong play or on timeout.
REQ-014 pronto  output  1  round ended (any outcome).
REQ-015 db_timeout  output  1  round ended on timeout.
REQ-016 db_estado  output  4  current state code, for the 7-segment debug display.

Function
REQ-017 Moore FSM; every output SHALL be a function of the current state only, except the internal timeout compare.
REQ-018 State codes: inicial=0x0, preparacao=0x1, espera_jogada=0x2, registra=0x4, comparacao=0x5, proximo=0x6, fim_acerto=0xA, fim_timeout=0xD, fim_erro=0xE; unused codes SHALL go to inicial on the next edge.
REQ-019 inicial: iniciar=1 -> preparacao; else stay.
REQ-020 preparacao: zeraC=1, zeraR=1; unconditional -> espera_jogada (1 cycle).
REQ-021 espera_jogada: jogada=1 -> registra; else timeout count reached -> fim_timeout; else stay.
REQ-022 jogada and timeout in the same cycle: jogada wins (-> registra).
REQ-023 registra: registraR=1; unconditional -> comparacao.
REQ-024 comparacao: igual=0 -> fim_erro; igual=1 and fimC=1 -> fim_acerto; igual=1 and fimC=0 -> proximo.
REQ-025 proximo: contaC=1; unconditional -> espera_jogada.
REQ-026 fim_acerto: pronto=1, acertou=1. fim_erro: pronto=1, errou=1. fim_timeout: pronto=1, errou=1, db_timeout=1.
REQ-027 Any fim_* state: iniciar=1 -> preparacao; else stay (outputs held).
REQ-028 Timeout counter: ceil(log2(TIMEOUT)) bits, unsigned; cleared on every cycle the state is not espera_jogada; increments by 1 each cycle in espera_jogada.
REQ-029 Timeout condition: counter == TIMEOUT-1 while in espera_jogada; fim_timeout is therefore entered exactly TIMEOUT cycles after entering espera_jogada with no jogada.
REQ-030 Counter SHALL restart from 0 on each re-entry to espera_jogada (per-play timeout, not per-round); counter SHALL never wrap.
REQ-031 iniciar is ignored in all states except inicial and fim_*.
REQ-032 All outputs not listed as 1 for a state SHALL be 0 in that state.

Reset
REQ-033 reset=1 SHALL immediately force state inicial and timeout counter 0, independent of clock.
REQ-034 During and after reset: all control and status outputs 0, db_estado=0x0.
REQ-035 Reset asserted mid-round (any state) SHALL abort the round; no fim_* output pulses.

Verification (bench with TIMEOUT=20)
REQ-036 reset pulse, iniciar=0 for 15 cycles -> db_estado=0x0, all outputs 0.
REQ-037 iniciar=1 one cycle -> preparacao one cycle with zeraC=zeraR=1, then db_estado=0x2, pronto=0.
REQ-038 16 jogada pulses with igual=1, fimC=1 on the 16th -> 15 contaC pulses, then db_estado=0xA, acertou=1, pronto=1, errou=0.
REQ-039 3 correct plays then jogada with igual=0 -> db_estado=0xE, errou=1, pronto=1, acertou=0, db_timeout=0.
REQ-040 after first correct play, no jogada for 20 cycles -> fim_timeout on 20th edge, db_estado=0xD, errou=1, db_timeout=1; jogada on cycle 20 instead -> registra.
REQ-041 from fim_erro, iniciar=1 -> preparacao, outputs cleared; reset asserted in espera_jogada -> db_estado=0x0 immediately.
